io_irq_bridge: RTL and testbench

Parametrised CPU-to-peripheral bridge with an integrated vectored interrupt controller. It sits between the CPU data/address buses and up to 16 memory-mapped peripheral drivers such as the LED, LCD and test devices. It decodes one-hot device selects and forwards read/write strobes. It also latches per-channel interrupts with mask and mode registers, and runs a request/acknowledge/end-of-interrupt handshake with the CPU. It holds the interrupt return address.

---
 rtl/io_irq_bridge_if.sv | 36 +++
 rtl/io_irq_bridge.sv | 148 ++++++++++++++
 tb/tb_io_irq_bridge.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_irq_bridge_if.sv
// CPU/peripheral/interrupt signal bundle for io_irq_bridge.
// master = CPU and device side, slave = the bridge.
interface io_irq_bridge_if #(
  parameter int NUM_DEV = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16
);
  logic [ADDR_W-1:0]         cpu_addr;
  logic                      cpu_read;
  logic                      cpu_write;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic [NUM_DEV-1:0]        dev_read;
  logic [NUM_DEV-1:0]        dev_write;
  logic [DATA_W-1:0]         dev_wdata;
  logic [NUM_DEV*DATA_W-1:0] dev_rdata;
  logic [NUM_DEV-1:0]        dev_irq;
  logic                      int_req;
  logic [3:0]                int_vector;
  logic                      int_ack;
  logic                      int_eoi;
  logic                      store_retaddr;
  logic [DATA_W-1:0]         retaddr;

  modport master (
    output cpu_addr, cpu_read, cpu_write, cpu_wdata, dev_rdata, dev_irq,
           int_ack, int_eoi, store_retaddr,
    input  cpu_rdata, dev_read, dev_write, dev_wdata, int_req, int_vector, retaddr
  );

  modport slave (
    input  cpu_addr, cpu_read, cpu_write, cpu_wdata, dev_rdata, dev_irq,
           int_ack, int_eoi, store_retaddr,
    output cpu_rdata, dev_read, dev_write, dev_wdata, int_req, int_vector, retaddr
  );
endinterface

// File: rtl/io_irq_bridge.sv
// CPU-to-peripheral bridge: one-hot device decode with strobe forwarding, plus a
// vectored interrupt controller (mask/pending/mode, req/ack/eoi handshake, return address).
module io_irq_bridge #(
  parameter int NUM_DEV = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  io_irq_bridge_if.slave bus
);
  localparam int N = NUM_DEV;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        vec_q, vec_d;
  logic [N-1:0]      mask_q, mask_d;
  logic [N-1:0]      pend_q, pend_d;
  logic [N-1:0]      mode_q, mode_d;
  logic [N-1:0]      irq_prev_q;
  logic [DATA_W-1:0] retaddr_q, retaddr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              is_reg;
  logic [1:0]        reg_idx;
  logic [N-1:0]      addr_bits, sel_oh;
  logic              reg_we, mask_we, pend_we, mode_we, ret_we;
  logic [DATA_W-1:0] dev_rd, reg_rd;
  logic [N-1:0]      irq_set, w1c, ack_clr, vec_oh, active_q;
  logic              ack_fire, vec_live, int_req;

  function automatic logic [3:0] low_idx(input logic [N-1:0] v);
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) low_idx = 4'(i);
    end
  endfunction

  // Device decode: lowest set address bit wins, internal window disables all devices.
  assign is_reg    = bus.cpu_addr[ADDR_W-1];
  assign reg_idx   = bus.cpu_addr[1:0];
  assign addr_bits = bus.cpu_addr[N-1:0];
  assign sel_oh    = is_reg ? '0 : (addr_bits & (~addr_bits + N'(1)));

  assign bus.dev_read  = bus.cpu_read  ? sel_oh : '0;
  assign bus.dev_write = bus.cpu_write ? sel_oh : '0;
  assign bus.dev_wdata = bus.cpu_wdata;

  always_comb begin
    dev_rd = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_oh[i]) dev_rd = bus.dev_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    reg_rd = '0;
    case (reg_idx)
      2'd0:    reg_rd[N-1:0] = mask_q;
      2'd1:    reg_rd[N-1:0] = pend_q;
      2'd2:    reg_rd[N-1:0] = mode_q;
      default: reg_rd        = retaddr_q;
    endcase
  end

  assign reg_we  = bus.cpu_write && is_reg;
  assign mask_we = reg_we && (reg_idx == 2'd0);
  assign pend_we = reg_we && (reg_idx == 2'd1);
  assign mode_we = reg_we && (reg_idx == 2'd2);
  assign ret_we  = reg_we && (reg_idx == 2'd3);

  assign vec_oh   = N'(1) << vec_q;
  assign ack_fire = (state_q == REQ) && bus.int_ack;
  assign ack_clr  = ack_fire ? vec_oh : '0;
  assign w1c      = pend_we ? bus.cpu_wdata[N-1:0] : '0;
  assign irq_set  = (bus.dev_irq & ~irq_prev_q & mode_q) | (bus.dev_irq & ~mode_q);

  // Clears are applied first so that a same-cycle set survives.
  assign pend_d    = (pend_q & ~(w1c | ack_clr)) | irq_set;
  assign mask_d    = mask_we ? bus.cpu_wdata[N-1:0] : mask_q;
  assign mode_d    = mode_we ? bus.cpu_wdata[N-1:0] : mode_q;
  assign retaddr_d = (bus.store_retaddr || ret_we) ? bus.cpu_wdata : retaddr_q;
  assign rdata_d   = bus.cpu_read ? (is_reg ? reg_rd : dev_rd) : rdata_q;

  assign active_q = pend_q & mask_q;
  // Withdraw looks at next-state values so int_req drops on the edge the source goes away.
  assign vec_live = |(pend_d & mask_d & vec_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      pend_q     <= '0;
      mode_q     <= '0;
      irq_prev_q <= '0;
      retaddr_q  <= '0;
      rdata_q    <= '0;
    end else begin
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      mode_q     <= mode_d;
      irq_prev_q <= bus.dev_irq;
      retaddr_q  <= retaddr_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (|active_q) begin
          state_d = REQ;
          vec_d   = low_idx(active_q);
        end
      end
      REQ: begin
        if (bus.int_ack)    state_d = SERVICE;
        else if (!vec_live) state_d = IDLE;
      end
      SERVICE: begin
        if (bus.int_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_req = 1'b0;
    if (state_q == REQ) int_req = 1'b1;
  end

  assign bus.int_req    = int_req;
  assign bus.int_vector = vec_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.retaddr    = retaddr_q;
endmodule

// File: tb/tb_io_irq_bridge.sv
// Bench for io_irq_bridge: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the bridge.
module tb_io_irq_bridge;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  io_irq_bridge_if #(.NUM_DEV(4), .DATA_W(16), .ADDR_W(16)) bus ();

  io_irq_bridge #(.NUM_DEV(4), .DATA_W(16), .ADDR_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [3:0]  m_mask, m_pend, m_mode, m_prev;
  logic [15:0] m_ret, m_rdata;
  bit          m_req, m_srv;
  int          m_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowbit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mask = '0; m_pend = '0; m_mode = '0; m_prev = '0;
    m_ret = '0; m_rdata = '0; m_req = 0; m_srv = 0; m_vec = 0;
  endtask

  // One clock: check outputs, advance the model, cross the edge, clear one-cycle strobes.
  task automatic tick();
    int          lb, idx;
    bit          is_reg, wr, n_req, n_srv;
    int          n_vec;
    logic [3:0]  exp_dr, exp_dw, setv, clrv, n_pend, n_mask, n_mode;
    logic [15:0] n_ret, n_rd;
    #1;
    lb     = lowbit(bus.cpu_addr[3:0]);
    is_reg = bus.cpu_addr[15];
    idx    = int'(bus.cpu_addr[1:0]);
    exp_dr = '0;
    exp_dw = '0;
    if (!is_reg && lb >= 0) begin
      if (bus.cpu_read)  exp_dr[lb] = 1'b1;
      if (bus.cpu_write) exp_dw[lb] = 1'b1;
    end
    chk("dev_read",  bus.dev_read,  exp_dr);
    chk("dev_write", bus.dev_write, exp_dw);
    chk("dev_wdata", bus.dev_wdata, bus.cpu_wdata);
    chk("int_req",   bus.int_req,   m_req);
    chk("int_vec",   bus.int_vector, m_vec);
    chk("cpu_rdata", bus.cpu_rdata, m_rdata);
    chk("retaddr",   bus.retaddr,   m_ret);

    n_rd = m_rdata;
    if (bus.cpu_read) begin
      if (is_reg) begin
        case (idx)
          0:       n_rd = {12'h0, m_mask};
          1:       n_rd = {12'h0, m_pend};
          2:       n_rd = {12'h0, m_mode};
          default: n_rd = m_ret;
        endcase
      end else if (lb >= 0) n_rd = bus.dev_rdata[lb*16 +: 16];
      else n_rd = '0;
    end
    wr = bus.cpu_write && is_reg;
    for (int i = 0; i < 4; i++)
      setv[i] = m_mode[i] ? (bus.dev_irq[i] && !m_prev[i]) : bus.dev_irq[i];
    clrv = (wr && idx == 1) ? bus.cpu_wdata[3:0] : 4'h0;
    if (m_req && bus.int_ack) clrv[m_vec] = 1'b1;
    n_pend = (m_pend & ~clrv) | setv;
    n_mask = (wr && idx == 0) ? bus.cpu_wdata[3:0] : m_mask;
    n_mode = (wr && idx == 2) ? bus.cpu_wdata[3:0] : m_mode;
    n_ret  = (bus.store_retaddr || (wr && idx == 3)) ? bus.cpu_wdata : m_ret;

    n_req = m_req; n_srv = m_srv; n_vec = m_vec;
    if (m_req) begin
      if (bus.int_ack) begin
        n_req = 0; n_srv = 1;
      end else if (!(n_pend[m_vec] && n_mask[m_vec])) n_req = 0;
    end else if (m_srv) begin
      if (bus.int_eoi) n_srv = 0;
    end else if ((m_pend & m_mask) != 4'h0) begin
      n_req = 1;
      n_vec = lowbit(m_pend & m_mask);
    end

    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      m_mask = n_mask; m_pend = n_pend; m_mode = n_mode; m_prev = bus.dev_irq;
      m_ret = n_ret; m_rdata = n_rd; m_req = n_req; m_srv = n_srv; m_vec = n_vec;
    end
    bus.cpu_read = 0; bus.cpu_write = 0; bus.int_ack = 0;
    bus.int_eoi = 0; bus.store_retaddr = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_write = 1;
    tick();
  endtask

  task automatic rd(input logic [15:0] a);
    bus.cpu_addr = a; bus.cpu_read = 1;
    tick();
  endtask

  task automatic async_reset();
    #2 rst_n = 0;
    #1 model_reset();
    chk("arst_req", bus.int_req, 0);
    chk("arst_rdata", bus.cpu_rdata, 0);
    tick();
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_bad = 0;
    rst_n = 0;
    bus.cpu_addr = '0; bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_wdata = '0;
    bus.dev_rdata = {16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0};
    bus.dev_irq = '0; bus.int_ack = 0; bus.int_eoi = 0; bus.store_retaddr = 0;
    model_reset();
    #1;
    tick(); tick();
    rst_n = 1;
    chk("rst_req", bus.int_req, 0);

    // Reset in the middle of a request
    wr(16'h8000, 16'h0003);
    bus.dev_irq = 4'b0001;
    tick(); tick();
    chk("pre_rst_req", bus.int_req, 1);
    bus.dev_irq = 4'b0000;
    async_reset();
    tick();
    for (int r = 0; r < 4; r++) begin
      rd(16'h8000 | 16'(r));
      chk("post_rst_reg", bus.cpu_rdata, 0);
    end

    // Device decode
    bus.cpu_addr = 16'h0004; bus.cpu_wdata = 16'hABCD; bus.cpu_write = 1;
    #1;
    chk("dec_wr", bus.dev_write, 4'b0100);
    chk("dec_wdata", bus.dev_wdata, 16'hABCD);
    tick();
    rd(16'h0006); chk("dec_low_wins", bus.cpu_rdata, 16'hD1D1);
    rd(16'h0018); chk("dec_dev3", bus.cpu_rdata, 16'hD3D3);
    rd(16'h0010); chk("dec_none", bus.cpu_rdata, 16'h0000);

    // Edge mode priority: channels 1 and 3 together
    wr(16'h8000, 16'h000F);
    wr(16'h8002, 16'h000F);
    bus.dev_irq = 4'b1010;
    tick();
    bus.dev_irq = 4'b0000;
    chk("lat_n", bus.int_req, 0);
    tick();
    chk("lat_n1", bus.int_req, 1);
    chk("vec_first", bus.int_vector, 1);
    bus.int_ack = 1; tick();
    chk("ack_drop", bus.int_req, 0);
    bus.int_eoi = 1; tick();
    tick();
    chk("second_req", bus.int_req, 1);
    chk("vec_second", bus.int_vector, 3);
    bus.int_ack = 1; tick();
    bus.int_eoi = 1; tick();

    // Level mode re-pend on channel 0
    wr(16'h8002, 16'h0000);
    wr(16'h8000, 16'h0001);
    bus.dev_irq = 4'b0001;
    tick(); tick();
    chk("lvl_req", bus.int_req, 1);
    chk("lvl_vec", bus.int_vector, 0);
    bus.int_ack = 1; tick();
    rd(16'h8001); chk("lvl_repend", bus.cpu_rdata, 16'h0001);
    bus.int_eoi = 1; tick();
    tick();
    chk("lvl_rereq", bus.int_req, 1);
    bus.dev_irq = 4'b0000;
    tick();
    wr(16'h8001, 16'h0001);
    chk("lvl_w1c_drop", bus.int_req, 0);
    repeat (4) tick();
    chk("lvl_quiet", bus.int_req, 0);

    // Withdraw by masking while in REQ
    wr(16'h8002, 16'h0004);
    wr(16'h8000, 16'h0004);
    bus.dev_irq = 4'b0100;
    tick();
    bus.dev_irq = 4'b0000;
    tick();
    chk("wd_req", bus.int_req, 1);
    chk("wd_vec", bus.int_vector, 2);
    wr(16'h8000, 16'h0000);
    chk("wd_drop", bus.int_req, 0);
    rd(16'h8001); chk("wd_pend", bus.cpu_rdata, 16'h0004);
    wr(16'h8001, 16'h0004);

    // Return address capture
    wr(16'h8003, 16'h5555);
    chk("ret_reg", bus.retaddr, 16'h5555);
    bus.cpu_addr = 16'h8003; bus.cpu_wdata = 16'h1234;
    bus.cpu_write = 1; bus.store_retaddr = 1;
    tick();
    chk("ret_both", bus.retaddr, 16'h1234);
    rd(16'h8003); chk("ret_read", bus.cpu_rdata, 16'h1234);
    bus.cpu_addr = 16'h0000; bus.cpu_wdata = 16'hBEEF; bus.store_retaddr = 1;
    tick();
    chk("ret_store", bus.retaddr, 16'hBEEF);

    // Random traffic
    for (int it = 0; it < 3000; it++) begin
      bus.dev_rdata = {$urandom, $urandom};
      bus.cpu_addr  = 16'($urandom);
      bus.cpu_wdata = 16'($urandom);
      bus.cpu_read  = ($urandom % 3 == 0);
      bus.cpu_write = !bus.cpu_read && ($urandom % 4 == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom % 8 == 0) bus.dev_irq[b] = ~bus.dev_irq[b];
      bus.int_ack       = ($urandom % 3 == 0);
      bus.int_eoi       = ($urandom % 5 == 0);
      bus.store_retaddr = ($urandom % 16 == 0);
      if (it == 1500) async_reset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
